// File: rtl/shift_pkg.sv
// Shared definitions for the shift-pass sequencer and its fixed-K shifter.
// Shift-type codes, sequencer state encoding and default sizing constants.
package shift_pkg;

  localparam logic [2:0] SHIFT_LSR = 3'b000;
  localparam logic [2:0] SHIFT_LSL = 3'b001;
  localparam logic [2:0] SHIFT_ASR = 3'b010;
  localparam logic [2:0] SHIFT_ASL = 3'b011;
  localparam logic [2:0] SHIFT_ROR = 3'b100;
  localparam logic [2:0] SHIFT_ROL = 3'b101;

  localparam int SHIFT_WIDTH = 8;
  localparam int SHIFT_K     = 3;
  localparam int SHIFT_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/shift_pass_sequencer.sv
// Runs an operand through an external fixed-K shifter for a requested number of passes.
// Optional SHIFT_PASS_EARLY_EXIT_EN: stop as soon as the operand becomes zero.
//
// state   | meaning
// IDLE    | ready for a request
// RUN     | one shifter pass per cycle, Acc fed back through the shifter
// DONE    | response valid, held until RspReady
module shift_pass_sequencer
  import shift_pkg::*;
#(
  parameter int WIDTH = SHIFT_WIDTH,
  parameter int K     = SHIFT_K,
  parameter int CNT_W = SHIFT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ReqValid,
  output logic             ReqReady,
  input  logic [WIDTH-1:0] ReqNum,
  input  logic [2:0]       ReqType,
  input  logic [CNT_W-1:0] ReqPasses,
  output logic [WIDTH-1:0] ShfNum,
  output logic [2:0]       ShfType,
  input  logic [WIDTH-1:0] ShfOut,
  output logic             RspValid,
  input  logic             RspReady,
  output logic [WIDTH-1:0] RspData,
  output logic [CNT_W-1:0] RspPasses,
  output logic             Busy
);

  // K only matters to the attached shifter; reject configurations it cannot honour.
  if (K < 1 || K >= WIDTH) begin : g_bad_k
    $error("shift_pass_sequencer: K must be in 1..WIDTH-1");
  end

  state_t           state, state_nxt;
  logic [WIDTH-1:0] acc, acc_nxt;
  logic [2:0]       type_reg, type_nxt;
  logic [CNT_W-1:0] remain, remain_nxt;
  logic [CNT_W-1:0] pass_cnt, pass_cnt_nxt;
  logic             zero_exit;

`ifdef SHIFT_PASS_EARLY_EXIT_EN
  // Zero is a fixed point of every shift type, so further passes change nothing.
  assign zero_exit = (ShfOut == '0);
`else
  assign zero_exit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      acc      <= '0;
      type_reg <= '0;
      remain   <= '0;
      pass_cnt <= '0;
    end else begin
      state    <= state_nxt;
      acc      <= acc_nxt;
      type_reg <= type_nxt;
      remain   <= remain_nxt;
      pass_cnt <= pass_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    acc_nxt      = acc;
    type_nxt     = type_reg;
    remain_nxt   = remain;
    pass_cnt_nxt = pass_cnt;
    ReqReady     = 1'b0;
    RspValid     = 1'b0;
    case (state)
      ST_IDLE: begin
        ReqReady = 1'b1;
        if (ReqValid) begin
          acc_nxt      = ReqNum;
          type_nxt     = ReqType;
          remain_nxt   = ReqPasses;
          pass_cnt_nxt = '0;
          state_nxt    = (ReqPasses != '0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        acc_nxt      = ShfOut;
        remain_nxt   = remain - CNT_W'(1);
        pass_cnt_nxt = pass_cnt + CNT_W'(1);
        // Exiting on remain==1 means the down-counter never wraps, even at the max count.
        if (remain == CNT_W'(1) || zero_exit) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        RspValid = 1'b1;
        if (RspReady) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign ShfNum    = acc;
  assign ShfType   = type_reg;
  assign RspData   = acc;
  assign RspPasses = pass_cnt;
  assign Busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_shift_pass_sequencer.sv
// Scoreboard bench for shift_pass_sequencer with a behavioural fixed-K shifter attached.
// Honours SHIFT_PASS_EARLY_EXIT_EN in its reference model.
module tb_shift_pass_sequencer;

  localparam int WIDTH = 8;
  localparam int K     = 3;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             ReqValid = 1'b0;
  logic             ReqReady;
  logic [WIDTH-1:0] ReqNum = '0;
  logic [2:0]       ReqType = '0;
  logic [CNT_W-1:0] ReqPasses = '0;
  logic [WIDTH-1:0] ShfNum;
  logic [2:0]       ShfType;
  logic [WIDTH-1:0] ShfOut;
  logic             RspValid;
  logic             RspReady = 1'b0;
  logic [WIDTH-1:0] RspData;
  logic [CNT_W-1:0] RspPasses;
  logic             Busy;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic [CNT_W-1:0] passes;
    logic [2:0]       typ;
    int               lat;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  shift_pass_sequencer #(.WIDTH(WIDTH), .K(K), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqNum(ReqNum),
    .ReqType(ReqType), .ReqPasses(ReqPasses),
    .ShfNum(ShfNum), .ShfType(ShfType), .ShfOut(ShfOut),
    .RspValid(RspValid), .RspReady(RspReady), .RspData(RspData),
    .RspPasses(RspPasses), .Busy(Busy)
  );

  function automatic logic [WIDTH-1:0] shf(input logic [WIDTH-1:0] x, input logic [2:0] t);
    logic [WIDTH-1:0] r;
    case (t)
      3'b000:  r = x >> K;
      3'b001:  r = x << K;
      3'b010:  r = WIDTH'($signed(x) >>> K);
      3'b011:  r = x << K;
      3'b100:  r = (x >> K) | (x << (WIDTH - K));
      3'b101:  r = (x << K) | (x >> (WIDTH - K));
      default: r = '0;
    endcase
    return r;
  endfunction

  always_comb ShfOut = shf(ShfNum, ShfType);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model(input logic [WIDTH-1:0] num, input logic [2:0] t,
                       input logic [CNT_W-1:0] p, output exp_t e);
    logic [WIDTH-1:0] d;
    int n;
    d = num;
    n = 0;
    for (int i = 0; i < int'(p); i++) begin
      d = shf(d, t);
      n++;
`ifdef SHIFT_PASS_EARLY_EXIT_EN
      if (d == '0) break;
`endif
    end
    e.data   = d;
    e.passes = CNT_W'(n);
    e.typ    = t;
    e.lat    = n + 1;
  endtask

  // Drive a request and return just after its accepting edge.
  task automatic send(input logic [WIDTH-1:0] num, input logic [2:0] t, input logic [CNT_W-1:0] p);
    exp_t e;
    int waited;
    waited = 0;
    @(negedge clk);
    while (!ReqReady && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    chk("req_ready_before_send", 32'(ReqReady), 32'd1);
    ReqValid  = 1'b1;
    ReqNum    = num;
    ReqType   = t;
    ReqPasses = p;
    model(num, t, p, e);
    sb.push_back(e);
    @(posedge clk);
  endtask

  // Wait for the response, check it, optionally stall it, then complete the handshake.
  // In scramble mode ReqValid stays high with a changing ReqNum; at the handshake the
  // inputs switch to a follow-up request that must only be taken once back in IDLE.
  task automatic collect(input int hold, input bit scramble);
    exp_t e, e2;
    int lat;
    logic [WIDTH-1:0] held_data;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    @(negedge clk);
    lat = 1;
    if (!scramble) ReqValid = 1'b0;
    while (!RspValid && lat < 100) begin
      if (scramble) ReqNum = WIDTH'($urandom);
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'(e.lat));
    chk("rsp_data", 32'(RspData), 32'(e.data));
    chk("rsp_passes", 32'(RspPasses), 32'(e.passes));
    chk("shf_type", 32'(ShfType), 32'(e.typ));
    chk("busy_in_done", 32'(Busy), 32'd1);
    held_data = RspData;
    for (int i = 0; i < hold; i++) begin
      if (scramble) ReqNum = WIDTH'($urandom);
      @(negedge clk);
      chk("hold_rsp_valid", 32'(RspValid), 32'd1);
      chk("hold_rsp_data", 32'(RspData), 32'(held_data));
      chk("hold_req_ready", 32'(ReqReady), 32'd0);
    end
    RspReady = 1'b1;
    if (scramble) begin
      ReqNum    = 8'h5A;
      ReqType   = 3'b101;
      ReqPasses = '0;
      model(8'h5A, 3'b101, '0, e2);
      sb.push_back(e2);
    end
    @(negedge clk);
    RspReady = 1'b0;
    chk("rsp_valid_cleared", 32'(RspValid), 32'd0);
    chk("req_ready_back", 32'(ReqReady), 32'd1);
    chk("busy_cleared", 32'(Busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_req_ready", 32'(ReqReady), 32'd1);
    chk("reset_rsp_valid", 32'(RspValid), 32'd0);
    chk("reset_busy", 32'(Busy), 32'd0);
    chk("reset_shf_num", 32'(ShfNum), 32'd0);
    chk("reset_shf_type", 32'(ShfType), 32'd0);
    chk("reset_rsp_data", 32'(RspData), 32'd0);
    chk("reset_rsp_passes", 32'(RspPasses), 32'd0);
    rst_n = 1'b1;

    send(8'hB4, 3'b000, 4'd2);   collect(0, 1'b0);
    send(8'h5A, 3'b010, 4'd0);   collect(0, 1'b0);
    send(8'h01, 3'b001, 4'd5);   collect(0, 1'b0);
    send(8'h81, 3'b100, 4'd1);   collect(4, 1'b0);
    send(8'hC3, 3'b010, 4'd3);   collect(1, 1'b0);
    send(8'h81, 3'b101, 4'd15);  collect(0, 1'b0);
    send(8'h77, 3'b110, 4'd2);   collect(0, 1'b0);

    // ReqValid left high through RUN/DONE; follow-up request taken only from IDLE.
    send(8'hB4, 3'b000, 4'd4);   collect(2, 1'b1);
    @(posedge clk);
    collect(0, 1'b0);

    // Reset in the middle of a long run aborts the transaction.
    send(8'hFF, 3'b100, 4'd15);
    void'(sb.pop_back());
    @(negedge clk);
    ReqValid = 1'b0;
    repeat (3) @(negedge clk);
    chk("busy_mid_run", 32'(Busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_rsp_valid", 32'(RspValid), 32'd0);
    chk("abort_busy", 32'(Busy), 32'd0);
    chk("abort_shf_num", 32'(ShfNum), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_req_ready", 32'(ReqReady), 32'd1);
    chk("post_reset_rsp_valid", 32'(RspValid), 32'd0);
    send(8'hB4, 3'b000, 4'd1);   collect(0, 1'b0);
    chk("fresh_after_reset_expected", 32'(shf(8'hB4, 3'b000)), 32'h16);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
